fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction queue between the instruction fetch unit (producer) and instruction decode (consumer).
- Decouples fetch from decode stalls.
- Each entry holds one fetched instruction plus its PC.
- Circular buffer with valid/ready handshakes on both sides and a synchronous flush for branch redirects and exceptions.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- ILEN, 32, instruction width in bits.
- XLEN, 32, PC width in bits.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all entries.
- fetch_valid_i  in  1  fetch side presents a valid instruction.
- fetch_ready_o  out  1  queue can accept an entry this cycle.
- instruction_i  in  ILEN  fetched instruction.
- pc_i  in  XLEN  PC of the fetched instruction.
- dec_ready_i  in  1  decode accepts the head entry this cycle.
- dec_valid_o  out  1  head entry is valid.
- instruction_o  out  ILEN  head instruction.
- pc_o  out  XLEN  head PC.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH entries of {instruction, pc}.
  - Head and tail pointers are $clog2(DEPTH)+1 bits wide; the MSB is a wrap bit.
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
  - Pointers wrap modulo 2*DEPTH; the index field wraps DEPTH-1 -> 0.
- Reset (asynchronous):
  - head = tail = 0, count_o = 0.
  - dec_valid_o = 0, fetch_ready_o = 1.
  - instruction_o = 0, pc_o = 0.
  - Storage contents are don't-care.
- fetch_ready_o = !full.
  - Combinational from state only; it does not depend on dec_ready_i or flush_i.
  - No combinational path exists from dec_ready_i to fetch_ready_o.
- push = fetch_valid_i & fetch_ready_o & !flush_i.
  - On push: instruction_i and pc_i are written at tail[idx], and tail increments.
- dec_valid_o = !empty & !flush_i.
- pop = dec_valid_o & dec_ready_i.
  - On pop: head increments.
- Output data and latency:
  - instruction_o and pc_o show the entry at head[idx] when !empty, and 0 when empty.
  - No bypass: an entry pushed in cycle N is first visible on dec_valid_o in cycle N+1.
  - Minimum latency is 1 cycle.
- Simultaneous push and pop when neither full nor empty: both pointers advance and count_o is unchanged.
- When full:
  - fetch_ready_o = 0, so no push occurs even if dec_ready_i = 1 in the same cycle.
  - The freed slot is accepted the next cycle.
- When empty: no pop occurs and dec_valid_o = 0. A push proceeds normally.
- count_o = tail - head, computed modulo 2*DEPTH; range 0..DEPTH.
- Flush:
  - flush_i has priority over push and pop.
  - At the clock edge, head = tail = 0 and count_o = 0.
  - A fetch_valid_i presented in the flush cycle is dropped.
  - dec_valid_o is forced low during the flush cycle.
  - Operation resumes normally the cycle after flush_i deasserts.
  - If flush_i is held for several cycles, the queue stays empty.
- Handshake rules:
  - Once fetch_valid_i is high, the producer holds instruction_i and pc_i stable until the entry is accepted or a flush occurs.
  - The queue holds dec_valid_o and the head data stable until the entry is popped or a flush occurs.
- Reset mid-operation: all state clears immediately regardless of clock, and outputs take their reset values.
- No overflow or underflow is possible by construction.
- Assertions required in the bench:
  - count_o <= DEPTH.
  - !(push when full).
  - !(pop when empty).

Test Plan:
- Reset, then idle -> fetch_ready_o=1, dec_valid_o=0, count_o=0, instruction_o=0, pc_o=0.
- Push 0x00000013 @pc 0x80000000 with dec_ready_i=0 -> next cycle dec_valid_o=1, instruction_o=0x00000013, pc_o=0x80000000, count_o=1. Then dec_ready_i=1 -> cycle after, dec_valid_o=0, count_o=0.
- DEPTH=4, dec_ready_i=0, push pc 0x0,0x4,0x8,0xC, then attempt 0x10 -> fetch_ready_o=0 with count_o=4. Raise dec_ready_i -> outputs in order 0x0,0x4,0x8,0xC, and 0x10 is accepted one cycle after the first pop.
- Continuous push and pop for 10 entries (pc 0x0..0x24), both valids and readies held high after the first fill -> count_o stays 1, outputs in order with no loss or duplication, and pointers wrap past index 3 correctly.
- Queue holding 3 entries, assert flush_i together with fetch_valid_i (pc 0x100) -> dec_valid_o=0 in the flush cycle. Next cycle count_o=0, the 0x100 entry is absent, and a new push of pc 0x200 appears first.
- Drop rst_n_i asynchronously mid-cycle with count_o=2 -> outputs go to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {instruction, pc} between fetch and decode.
// Valid/ready handshakes on both sides; synchronous flush empties the queue for redirects.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     fetch_valid_i,
    output logic                     fetch_ready_o,
    input  logic [ILEN-1:0]          instruction_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic                     dec_ready_i,
    output logic                     dec_valid_o,
    output logic [ILEN-1:0]          instruction_o,
    output logic [XLEN-1:0]          pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;

    logic empty;
    logic full;
    logic push;
    logic pop;

    always_comb begin
        empty = (head_q == tail_q);
        full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    end

    // Handshake decode; fetch_ready depends on state only, never on decode or flush.
    always_comb begin
        fetch_ready_o = !full;
        dec_valid_o   = !empty && !flush_i;
        push          = fetch_valid_i && fetch_ready_o && !flush_i;
        pop           = dec_valid_o && dec_ready_i;
        count_o       = tail_q - head_q;
    end

    // Head entry presented without bypass; zero when nothing is stored.
    always_comb begin
        instruction_o = '0;
        pc_o          = '0;
        if (!empty) begin
            instruction_o = instr_mem[head_q[AW-1:0]];
            pc_o          = pc_mem[head_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (flush_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
        end
    end

    // Payload storage needs no reset; it is only read while occupied.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[tail_q[AW-1:0]] <= instruction_i;
            pc_mem[tail_q[AW-1:0]]    <= pc_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked by a queue-based
// reference model; an issue process records accepted entries, a monitor pops and compares.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  fetch_valid;
    logic                  fetch_ready;
    logic [ILEN-1:0]       instruction;
    logic [XLEN-1:0]       pc;
    logic                  dec_ready;
    logic                  dec_valid;
    logic [ILEN-1:0]       instruction_out;
    logic [XLEN-1:0]       pc_out;
    logic [$clog2(DEPTH):0] count;

    int     total_cnt = 0;
    int     pass_cnt  = 0;
    entry_t sb[$];
    logic   exp_ready_q = 1'b1;

    fetch_queue #(.DEPTH(DEPTH), .ILEN(ILEN), .XLEN(XLEN)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .fetch_valid_i (fetch_valid),
        .fetch_ready_o (fetch_ready),
        .instruction_i (instruction),
        .pc_i          (pc),
        .dec_ready_i   (dec_ready),
        .dec_valid_o   (dec_valid),
        .instruction_o (instruction_out),
        .pc_o          (pc_out),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic prop(input string name, input logic cond);
        total_cnt++;
        assert (cond) pass_cnt++;
        else $display("FAIL %s: property violated at %0t", name, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue side: record each entry the queue is expected to accept at this edge.
    always @(posedge clk) begin
        entry_t e;
        if (!rst_n || flush) begin
            sb.delete();
        end else if (fetch_valid && exp_ready_q) begin
            e.instr = instruction;
            e.pc    = pc;
            sb.push_back(e);
        end
    end

    // Monitor: mid-cycle comparison of outputs against the model, popping on handshake.
    always @(negedge clk) begin
        int     sz;
        logic   exp_valid;
        entry_t hd;
        if (rst_n) begin
            sz        = sb.size();
            exp_valid = (sz > 0) && !flush;
            hd        = (sz > 0) ? sb[0] : '0;
            check("count", 64'(count), 64'(sz));
            check("fetch_ready", 64'(fetch_ready), 64'(sz < DEPTH));
            check("dec_valid", 64'(dec_valid), 64'(exp_valid));
            check("head_data", {instruction_out, pc_out}, 64'(hd));
            prop("count_le_depth", count <= DEPTH);
            prop("no_push_when_full", !(fetch_valid && fetch_ready && !flush && count == DEPTH));
            prop("no_pop_when_empty", !(dec_valid && dec_ready && count == 0));
            exp_ready_q = (sz < DEPTH);
            if (exp_valid && dec_ready) void'(sb.pop_front());
        end
    end

    initial begin
        logic acc;
        logic [XLEN-1:0] next_pc;

        rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
        instruction = '0; pc = '0;
        repeat (2) cycle();
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(fetch_ready), 64'd1);
        check("rst_valid", 64'(dec_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_data", {instruction_out, pc_out}, 64'd0);
        cycle();

        // Single entry, minimum latency.
        fetch_valid = 1'b1; instruction = 32'h0000_0013; pc = 32'h8000_0000;
        cycle();
        fetch_valid = 1'b0;
        check("single_valid", 64'(dec_valid), 64'd1);
        check("single_instr", 64'(instruction_out), 64'h13);
        check("single_pc", 64'(pc_out), 64'h8000_0000);
        check("single_count", 64'(count), 64'd1);
        dec_ready = 1'b1;
        cycle();
        check("single_drained_valid", 64'(dec_valid), 64'd0);
        check("single_drained_count", 64'(count), 64'd0);
        dec_ready = 1'b0;

        // Fill to full, then freed slot is taken one cycle after the first pop.
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1; pc = 32'(i * 4); instruction = 32'hA5A5_0000 | 32'(i);
            cycle();
        end
        pc = 32'h10; instruction = 32'hA5A5_0010;
        check("full_ready", 64'(fetch_ready), 64'd0);
        check("full_count", 64'(count), 64'd4);
        cycle();
        check("full_hold_count", 64'(count), 64'd4);
        dec_ready = 1'b1;
        cycle();
        check("first_pop_count", 64'(count), 64'd3);
        check("first_pop_ready", 64'(fetch_ready), 64'd1);
        cycle();
        check("refill_count", 64'(count), 64'd3);
        fetch_valid = 1'b0;
        repeat (4) cycle();
        check("drain_count", 64'(count), 64'd0);
        dec_ready = 1'b0;

        // Streaming: one entry in flight, pointers wrap.
        fetch_valid = 1'b1; pc = 32'h0; instruction = 32'h1111_0000;
        cycle();
        dec_ready = 1'b1;
        for (int k = 1; k < 10; k++) begin
            pc = 32'(k * 4); instruction = 32'h1111_0000 | 32'(k);
            cycle();
            check("stream_count", 64'(count), 64'd1);
        end
        fetch_valid = 1'b0;
        cycle();
        check("stream_end_count", 64'(count), 64'd0);
        dec_ready = 1'b0;

        // Flush with a concurrent fetch drops everything.
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1; pc = 32'h40 + 32'(i * 4); instruction = 32'h2222_0000 | 32'(i);
            cycle();
        end
        flush = 1'b1; pc = 32'h100; instruction = 32'h3333_0100;
        #1;
        check("flush_valid_low", 64'(dec_valid), 64'd0);
        cycle();
        flush = 1'b0;
        check("post_flush_count", 64'(count), 64'd0);
        pc = 32'h200; instruction = 32'h3333_0200;
        cycle();
        fetch_valid = 1'b0;
        check("post_flush_pc", 64'(pc_out), 64'h200);
        check("post_flush_count1", 64'(count), 64'd1);
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;

        // Asynchronous reset mid-cycle with two entries held.
        for (int i = 0; i < 2; i++) begin
            fetch_valid = 1'b1; pc = 32'h300 + 32'(i * 4); instruction = 32'h4444_0000 | 32'(i);
            cycle();
        end
        fetch_valid = 1'b0;
        check("pre_reset_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid", 64'(dec_valid), 64'd0);
        check("async_rst_ready", 64'(fetch_ready), 64'd1);
        check("async_rst_data", {instruction_out, pc_out}, 64'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Random traffic; producer holds its entry until accepted or flushed.
        next_pc = 32'h1000;
        fetch_valid = 1'b0;
        acc = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (!(fetch_valid && !acc && !flush)) begin
                fetch_valid = ($urandom_range(0, 99) < 60);
                instruction = $urandom;
                pc          = next_pc;
                next_pc     = next_pc + 32'd4;
            end
            flush     = ($urandom_range(0, 99) < 3);
            dec_ready = ($urandom_range(0, 99) < 50);
            #1;
            acc = fetch_valid && fetch_ready && !flush;
            @(posedge clk);
            #1;
        end
        fetch_valid = 1'b0; flush = 1'b0; dec_ready = 1'b1;
        repeat (DEPTH + 2) cycle();
        check("final_count", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
